snake_state_bank: RTL and testbench

SNAKE_STATE_BANK -- requirements
Module: snake_state_bank

---
 rtl/snake_state_bank.sv | 143 ++++++++++++++
 tb/tb_snake_state_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_state_bank.sv
// Double-buffered snake segment store: the processor writes a shadow bank, and a
// commit arms a swap into the display bank on the next frame_sync rising edge.
module snake_state_bank #(
   parameter  int                SEGS      = 36,
   parameter  int                SEG_W     = 10,
   parameter  int                ADDR_W    = 12,
   parameter  logic [ADDR_W-1:0] BASE_ADDR = 12'd3000,
   localparam int                LEN_W     = $clog2(SEGS + 1)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wren,
   input  logic [ADDR_W-1:0]       address,
   input  logic [31:0]             data,
   output logic [31:0]             q,
   input  logic                    frame_sync,
   output logic [SEGS*SEG_W-1:0]   snake_data,
   output logic [LEN_W-1:0]        snake_len,
   output logic                    armed,
   output logic                    swap_pulse,
   output logic [15:0]             frame_count
);

   localparam logic [ADDR_W-1:0] OFF_LEN    = ADDR_W'(SEGS);
   localparam logic [ADDR_W-1:0] OFF_COMMIT = ADDR_W'(SEGS + 1);
   localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(SEGS + 2);

   typedef enum logic [0:0] {IDLE = 1'b0, ARMED = 1'b1} state_t;

   state_t                  state_reg, state_next;
   logic                    fs_reg;
   logic                    dirty_reg;
   logic                    swap_pulse_reg;
   logic [15:0]             frame_count_reg;
   logic [LEN_W-1:0]        shadow_len_reg;
   logic [LEN_W-1:0]        disp_len_reg;
   logic [31:0]             q_reg;

   logic                    edge_det;
   logic                    swap_go;
   logic                    in_range;
   logic [ADDR_W-1:0]       offset;
   logic                    seg_wr;
   logic                    len_wr;
   logic                    commit_wr;
   logic [LEN_W-1:0]        len_in;
   logic [31:0]             rd_data;
   logic [SEGS*SEG_W-1:0]   shadow_flat;

   assign edge_det  = frame_sync & ~fs_reg;
   assign in_range  = (address >= BASE_ADDR);
   assign offset    = address - BASE_ADDR;
   assign seg_wr    = wren && in_range && (offset < OFF_LEN);
   assign len_wr    = wren && in_range && (offset == OFF_LEN);
   assign commit_wr = wren && in_range && (offset == OFF_COMMIT);
   assign len_in    = (data > 32'(SEGS)) ? LEN_W'(SEGS) : data[LEN_W-1:0];

   // A commit arriving with the swap edge re-arms for the following frame.
   always_comb begin
      state_next = state_reg;
      swap_go    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (commit_wr) state_next = ARMED;
         end
         ARMED: begin
            if (edge_det) begin
               swap_go = 1'b1;
               if (!commit_wr) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < SEGS; gi++) begin : g_seg
         logic [SEG_W-1:0] shadow_reg;
         logic [SEG_W-1:0] disp_reg;
         logic             seg_sel;

         assign seg_sel = seg_wr && (offset == ADDR_W'(gi));

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               shadow_reg <= '0;
               disp_reg   <= '0;
            end else begin
               if (swap_go) disp_reg <= shadow_reg;
               if (seg_sel) shadow_reg <= data[SEG_W-1:0];
            end
         end

         // Segments beyond the live length show the off-grid marker.
         assign snake_data[gi*SEG_W +: SEG_W] =
            (LEN_W'(gi) < disp_len_reg) ? disp_reg : {SEG_W{1'b1}};
         assign shadow_flat[gi*SEG_W +: SEG_W] = shadow_reg;
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      if (in_range) begin
         for (int i = 0; i < SEGS; i++) begin
            if (offset == ADDR_W'(i)) rd_data = 32'(shadow_flat[i*SEG_W +: SEG_W]);
         end
         if (offset == OFF_LEN)    rd_data = 32'(shadow_len_reg);
         if (offset == OFF_STATUS) rd_data = {frame_count_reg, 14'b0, (state_reg == ARMED), dirty_reg};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         fs_reg          <= 1'b0;
         dirty_reg       <= 1'b0;
         swap_pulse_reg  <= 1'b0;
         frame_count_reg <= '0;
         shadow_len_reg  <= '0;
         disp_len_reg    <= '0;
         q_reg           <= '0;
      end else begin
         state_reg      <= state_next;
         fs_reg         <= frame_sync;
         swap_pulse_reg <= swap_go;
         q_reg          <= rd_data;
         if (edge_det) frame_count_reg <= frame_count_reg + 16'd1;
         if (swap_go)  disp_len_reg    <= shadow_len_reg;
         if (len_wr)   shadow_len_reg  <= len_in;
         // A store landing with the swap leaves the shadow dirty again.
         if (seg_wr || len_wr) dirty_reg <= 1'b1;
         else if (swap_go)     dirty_reg <= 1'b0;
      end
   end

   assign q           = q_reg;
   assign snake_len   = disp_len_reg;
   assign armed       = (state_reg == ARMED);
   assign swap_pulse  = swap_pulse_reg;
   assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_snake_state_bank.sv
// Directed bench for snake_state_bank: load results go through a scoreboard queue,
// display/FSM outputs are checked against a small expected-bank builder.
module tb_snake_state_bank;
   localparam int SEGS  = 36;
   localparam int SEG_W = 10;
   localparam int DW    = SEGS * SEG_W;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              wren = 1'b0;
   logic              frame_sync = 1'b0;
   logic [11:0]       address = '0;
   logic [31:0]       data = '0;
   logic [31:0]       q;
   logic [DW-1:0]     snake_data;
   logic [5:0]        snake_len;
   logic              armed;
   logic              swap_pulse;
   logic [15:0]       frame_count;

   int                total = 0;
   int                bad = 0;
   int                pulses;
   logic [31:0]       exp_q[$];
   string             tag_q[$];

   snake_state_bank dut (
      .clock(clock), .reset(reset), .wren(wren), .address(address), .data(data),
      .q(q), .frame_sync(frame_sync), .snake_data(snake_data), .snake_len(snake_len),
      .armed(armed), .swap_pulse(swap_pulse), .frame_count(frame_count)
   );

   always #5 clock = ~clock;

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [11:0] a, input logic [31:0] d);
      address = a;
      data    = d;
      wren    = 1'b1;
      step;
      wren    = 1'b0;
   endtask

   task automatic load(input string tag, input logic [11:0] a, input logic [31:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      address = a;
      step;
      chk(tag_q.pop_front(), DW'(q), DW'(exp_q.pop_front()));
   endtask

   function automatic logic [DW-1:0] disp(input int len, input logic [SEG_W-1:0] s0, s1, s2);
      logic [DW-1:0]    r;
      logic [SEG_W-1:0] s;
      for (int i = 0; i < SEGS; i++) begin
         s = (i == 0) ? s0 : (i == 1) ? s1 : (i == 2) ? s2 : '0;
         r[i*SEG_W +: SEG_W] = (i < len) ? s : {SEG_W{1'b1}};
      end
      return r;
   endfunction

   function automatic logic [31:0] status(input logic [15:0] fc, input logic a, input logic d);
      return {fc, 14'b0, a, d};
   endfunction

   initial begin
      // reset state
      step; step;
      chk("rst_q", DW'(q), '0);
      chk("rst_len", DW'(snake_len), '0);
      chk("rst_armed", DW'(armed), '0);
      chk("rst_swap", DW'(swap_pulse), '0);
      chk("rst_fc", DW'(frame_count), '0);
      chk("rst_data", snake_data, disp(0, 0, 0, 0));
      reset = 1'b1;
      step;

      // basic commit and swap
      store(12'd3000, 32'd5);
      store(12'd3036, 32'd1);
      store(12'd3037, 32'd0);
      chk("arm1", DW'(armed), DW'(1'b1));
      frame_sync = 1'b1;
      step;
      chk("swap1_pulse", DW'(swap_pulse), DW'(1'b1));
      chk("swap1_data", snake_data, disp(1, 10'd5, 0, 0));
      chk("swap1_len", DW'(snake_len), DW'(6'd1));
      chk("swap1_armed", DW'(armed), '0);
      frame_sync = 1'b0;
      step;
      chk("swap1_pulse_end", DW'(swap_pulse), '0);
      load("status1", 12'd3038, status(16'd1, 1'b0, 1'b0));

      // edges without commit
      store(12'd3002, 32'd9);
      store(12'd3036, 32'd3);
      for (int i = 0; i < 10; i++) begin
         frame_sync = 1'b1;
         step;
         chk("idle_no_swap", DW'(swap_pulse), '0);
         frame_sync = 1'b0;
         step;
      end
      chk("idle_fc", DW'(frame_count), DW'(16'd11));
      chk("idle_data", snake_data, disp(1, 10'd5, 0, 0));
      load("status2", 12'd3038, status(16'd11, 1'b0, 1'b1));

      // held frame_sync gives one swap
      store(12'd3037, 32'd0);
      frame_sync = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step;
         if (swap_pulse) pulses++;
      end
      frame_sync = 1'b0;
      step;
      if (swap_pulse) pulses++;
      chk("held_pulses", DW'(pulses), DW'(1));
      chk("held_data", snake_data, disp(3, 10'd5, 0, 10'd9));
      chk("held_len", DW'(snake_len), DW'(6'd3));
      store(12'd3037, 32'd1);
      step; step;
      chk("rearm_armed", DW'(armed), DW'(1'b1));
      chk("rearm_no_swap", DW'(swap_pulse), '0);
      chk("held_fc", DW'(frame_count), DW'(16'd12));

      // segment store coincident with swap
      store(12'd3001, 32'd3);
      address    = 12'd3001;
      data       = 32'd7;
      wren       = 1'b1;
      frame_sync = 1'b1;
      step;
      wren       = 1'b0;
      frame_sync = 1'b0;
      chk("coin_seg_pulse", DW'(swap_pulse), DW'(1'b1));
      chk("coin_seg_data", snake_data, disp(3, 10'd5, 10'd3, 10'd9));
      load("coin_seg_load", 12'd3001, 32'd7);
      load("coin_seg_status", 12'd3038, status(16'd13, 1'b0, 1'b1));

      // commit coincident with swap
      store(12'd3037, 32'd0);
      address    = 12'd3037;
      wren       = 1'b1;
      frame_sync = 1'b1;
      step;
      wren       = 1'b0;
      frame_sync = 1'b0;
      chk("coin_cmt_pulse", DW'(swap_pulse), DW'(1'b1));
      chk("coin_cmt_armed", DW'(armed), DW'(1'b1));
      chk("coin_cmt_data", snake_data, disp(3, 10'd5, 10'd7, 10'd9));
      step;
      frame_sync = 1'b1;
      step;
      frame_sync = 1'b0;
      chk("coin_cmt_swap2", DW'(swap_pulse), DW'(1'b1));
      chk("coin_cmt_idle", DW'(armed), '0);
      step;

      // ignored stores and length saturation
      store(12'd2999, 32'd123);
      store(12'd3039, 32'd55);
      store(12'd3038, 32'd1);
      load("ign_status", 12'd3038, status(16'd15, 1'b0, 1'b0));
      load("ign_below", 12'd2999, 32'd0);
      load("ign_above", 12'd3039, 32'd0);
      store(12'd3036, 32'd100);
      load("sat_len", 12'd3036, 32'd36);
      load("seg0_keep", 12'd3000, 32'd5);
      store(12'd3037, 32'd0);
      frame_sync = 1'b1;
      step;
      frame_sync = 1'b0;
      chk("full_len", DW'(snake_len), DW'(6'd36));
      chk("full_data", snake_data, disp(36, 10'd5, 10'd7, 10'd9));
      step;

      // reset while armed
      store(12'd3037, 32'd0);
      chk("pre_rst_armed", DW'(armed), DW'(1'b1));
      reset = 1'b0;
      #1;
      chk("mid_rst_armed", DW'(armed), '0);
      chk("mid_rst_data", snake_data, disp(0, 0, 0, 0));
      chk("mid_rst_len", DW'(snake_len), '0);
      chk("mid_rst_fc", DW'(frame_count), '0);
      chk("mid_rst_q", DW'(q), '0);
      step; step;
      reset = 1'b1;
      frame_sync = 1'b1;
      step;
      frame_sync = 1'b0;
      chk("post_rst_swap", DW'(swap_pulse), '0);
      chk("post_rst_armed", DW'(armed), '0);
      chk("post_rst_data", snake_data, disp(0, 0, 0, 0));
      chk("post_rst_fc", DW'(frame_count), DW'(16'd1));
      step;
      load("post_rst_seg0", 12'd3000, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
